// File: rtl/inst_encoder_pkg.sv
//------------------------------------------------------------------------------
// Module : inst_encoder_pkg
// Brief  : Shared ISA constants for the instruction encoder and decoder.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package inst_encoder_pkg;

    // Field-level request operations; codes 24..31 are undefined (illegal)
    typedef enum logic [4:0] {
        OP_WAIT   = 5'd0,
        OP_AND    = 5'd1,
        OP_OR     = 5'd2,
        OP_XOR    = 5'd3,
        OP_ADD    = 5'd4,
        OP_ADDC   = 5'd5,
        OP_SUB    = 5'd6,
        OP_CMP    = 5'd7,
        OP_MOV    = 5'd8,
        OP_ANDI   = 5'd9,
        OP_ORI    = 5'd10,
        OP_XORI   = 5'd11,
        OP_ADDI   = 5'd12,
        OP_ADDCI  = 5'd13,
        OP_SUBI   = 5'd14,
        OP_CMPI   = 5'd15,
        OP_LSHI_L = 5'd16,
        OP_LSHI_R = 5'd17,
        OP_ASHI_L = 5'd18,
        OP_ASHI_R = 5'd19,
        OP_LOAD   = 5'd20,
        OP_STOR   = 5'd21,
        OP_BCOND  = 5'd22,
        OP_JCOND  = 5'd23
    } req_op_e;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } enc_state_e;

    // Major opcodes
    localparam logic [3:0] C_MAJ_RR    = 4'b0000;
    localparam logic [3:0] C_MAJ_SHIFT = 4'b1000;
    localparam logic [3:0] C_MAJ_MEM   = 4'b0100;
    localparam logic [3:0] C_MAJ_BR    = 4'b1100;

    // Register-register extension field
    localparam logic [3:0] C_EXT_AND  = 4'b0001;
    localparam logic [3:0] C_EXT_OR   = 4'b0010;
    localparam logic [3:0] C_EXT_XOR  = 4'b0011;
    localparam logic [3:0] C_EXT_ADD  = 4'b0101;
    localparam logic [3:0] C_EXT_ADDC = 4'b0111;
    localparam logic [3:0] C_EXT_SUB  = 4'b1001;
    localparam logic [3:0] C_EXT_CMP  = 4'b1011;
    localparam logic [3:0] C_EXT_MOV  = 4'b1101;

    // Immediate-op major nibbles
    localparam logic [3:0] C_IMM_ANDI  = 4'b0001;
    localparam logic [3:0] C_IMM_ORI   = 4'b0010;
    localparam logic [3:0] C_IMM_XORI  = 4'b0011;
    localparam logic [3:0] C_IMM_ADDI  = 4'b0101;
    localparam logic [3:0] C_IMM_ADDCI = 4'b0111;
    localparam logic [3:0] C_IMM_SUBI  = 4'b1001;
    localparam logic [3:0] C_IMM_CMPI  = 4'b1011;

    // Memory-group sub-codes
    localparam logic [3:0] C_SUB_LOAD  = 4'b0000;
    localparam logic [3:0] C_SUB_STOR  = 4'b0100;
    localparam logic [3:0] C_SUB_JCOND = 4'b1100;

    // Shift kind, followed by the direction bit in the word
    localparam logic [2:0] C_SHK_LSH = 3'b000;
    localparam logic [2:0] C_SHK_ASH = 3'b001;

    function automatic logic [15:0] pack_fields(input logic [3:0] a, input logic [3:0] b,
                                                input logic [3:0] c, input logic [3:0] d);
        return {a, b, c, d};
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_encoder_pack.sv
//------------------------------------------------------------------------------
// Module : inst_pack
// Brief  : Combinational request-to-ISA-word packer with illegal-request flag.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inst_pack
    import inst_encoder_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [3:0]  rd,
    input  logic [3:0]  rs,
    input  logic [7:0]  imm,
    output logic [15:0] word,
    output logic        illegal
);

    logic w_shift_bad;

    assign w_shift_bad = (imm[7:4] != 4'd0);

    always_comb begin
        word    = 16'h0000;
        illegal = 1'b0;
        case (op)
            OP_WAIT:   word = 16'h0000;
            OP_AND:    word = pack_fields(C_MAJ_RR, rd, C_EXT_AND,  rs);
            OP_OR:     word = pack_fields(C_MAJ_RR, rd, C_EXT_OR,   rs);
            OP_XOR:    word = pack_fields(C_MAJ_RR, rd, C_EXT_XOR,  rs);
            OP_ADD:    word = pack_fields(C_MAJ_RR, rd, C_EXT_ADD,  rs);
            OP_ADDC:   word = pack_fields(C_MAJ_RR, rd, C_EXT_ADDC, rs);
            OP_SUB:    word = pack_fields(C_MAJ_RR, rd, C_EXT_SUB,  rs);
            OP_CMP:    word = pack_fields(C_MAJ_RR, rd, C_EXT_CMP,  rs);
            OP_MOV:    word = pack_fields(C_MAJ_RR, rd, C_EXT_MOV,  rs);
            OP_ANDI:   word = {C_IMM_ANDI,  rd, imm};
            OP_ORI:    word = {C_IMM_ORI,   rd, imm};
            OP_XORI:   word = {C_IMM_XORI,  rd, imm};
            OP_ADDI:   word = {C_IMM_ADDI,  rd, imm};
            OP_ADDCI:  word = {C_IMM_ADDCI, rd, imm};
            OP_SUBI:   word = {C_IMM_SUBI,  rd, imm};
            OP_CMPI:   word = {C_IMM_CMPI,  rd, imm};
            OP_LSHI_L: begin
                word    = pack_fields(C_MAJ_SHIFT, rd, {C_SHK_LSH, 1'b0}, imm[3:0]);
                illegal = w_shift_bad;
            end
            OP_LSHI_R: begin
                word    = pack_fields(C_MAJ_SHIFT, rd, {C_SHK_LSH, 1'b1}, imm[3:0]);
                illegal = w_shift_bad;
            end
            OP_ASHI_L: begin
                word    = pack_fields(C_MAJ_SHIFT, rd, {C_SHK_ASH, 1'b0}, imm[3:0]);
                illegal = w_shift_bad;
            end
            OP_ASHI_R: begin
                word    = pack_fields(C_MAJ_SHIFT, rd, {C_SHK_ASH, 1'b1}, imm[3:0]);
                illegal = w_shift_bad;
            end
            OP_LOAD:   word = pack_fields(C_MAJ_MEM, rd, C_SUB_LOAD,  rs);
            OP_STOR:   word = pack_fields(C_MAJ_MEM, rd, C_SUB_STOR,  rs);
            OP_BCOND:  word = {C_MAJ_BR, rd, imm};
            OP_JCOND:  word = pack_fields(C_MAJ_MEM, rd, C_SUB_JCOND, rs);
            default:   illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/inst_encoder.sv
//------------------------------------------------------------------------------
// Module : inst_encoder
// Brief  : Field-level instruction encoder writing packed words to instruction
//          memory with an auto-incrementing address. Optional running checksum
//          output enabled by INST_ENCODER_CHECKSUM_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_load,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_op,
    input  logic [3:0]        req_rd,
    input  logic [3:0]        req_rs,
    input  logic [7:0]        req_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic              err_illegal
`ifdef INST_ENCODER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   C_DEPTH     = (ADDR_W + 1)'(DEPTH);

    enc_state_e        r_state;
    enc_state_e        w_next_state;
    logic              r_alive;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_wdata;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_err;
    logic [15:0]       w_word;
    logic              w_illegal;
    logic              w_accept;

    inst_pack u_pack (
        .op      (req_op),
        .rd      (req_rd),
        .rs      (req_rs),
        .imm     (req_imm),
        .word    (w_word),
        .illegal (w_illegal)
    );

    // r_alive keeps ready low through the reset cycle itself
    assign req_ready   = r_alive && (r_state == S_IDLE) && !r_full;
    assign w_accept    = req_valid && req_ready && !cfg_load;
    assign mem_we      = r_we && !cfg_load;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign word_count  = r_count;
    assign full        = r_full;
    assign err_illegal = r_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && !w_illegal) w_next_state = S_WRITE;
            S_WRITE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (cfg_load) begin
            w_next_state = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alive <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 16'h0000;
            r_count <= '0;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (cfg_load) begin
                r_we    <= 1'b0;
                r_addr  <= cfg_base;
                r_count <= '0;
                r_full  <= ({1'b0, cfg_base} >= C_DEPTH);
                r_err   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            if (w_illegal) begin
                                r_err <= 1'b1;
                            end else begin
                                r_we    <= 1'b1;
                                r_wdata <= w_word;
                            end
                        end
                    end
                    S_WRITE: begin
                        r_we    <= 1'b0;
                        r_count <= r_count + 1'b1;
                        // Last word: park the address and stop accepting
                        if (r_addr == C_LAST_ADDR) begin
                            r_full <= 1'b1;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                    default: r_we <= 1'b0;
                endcase
            end
        end
    end

`ifdef INST_ENCODER_CHECKSUM_EN
    logic [15:0] r_checksum;

    assign checksum = r_checksum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_checksum <= 16'h0000;
        end else if (cfg_load) begin
            r_checksum <= 16'h0000;
        end else if (r_we) begin
            r_checksum <= {r_checksum[14:0], r_checksum[15]} ^ r_wdata;
        end
    end
`endif

endmodule

`default_nettype wire
